// File: rtl/instr_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_loader_pkg
// Shared definitions for the instruction loader:
//   - byte-lane constants used by the little-endian word assembler
//   - the loader FSM state encoding (state_t)
//   - word_addr(): byte address of word i, wrapping modulo 2^32
// The CHECK state only exists when INSTR_LOADER_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
package instr_loader_pkg;

  localparam int LANES      = 4;
  localparam int LANE_W     = 8;
  localparam int WORD_W     = LANES * LANE_W;
  localparam int LANE_CNT_W = $clog2(LANES);

  // Index of the most significant byte lane; its arrival completes a word.
  localparam logic [LANE_CNT_W-1:0] LANE_LAST = LANE_CNT_W'(LANES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_HOLD   = 3'd2,
`ifdef INSTR_LOADER_CHECKSUM_EN
    ST_FINISH = 3'd3,
    ST_CHECK  = 3'd4
`else
    ST_FINISH = 3'd3
`endif
  } state_t;

  // Byte address of word idx; the 32-bit sum wraps naturally.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [15:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/instr_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Assembles four consecutive accepted bytes into one 32-bit word, least
// significant byte first. word_valid is a single-cycle combinational pulse on
// the cycle the 4th byte is accepted; word is valid only while word_valid=1.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-low
//   clear      in   drop any partially assembled word
//   byte_en    in   byte_in is accepted this cycle
//   byte_in    in   [7:0] incoming byte
//   word_valid out  4th byte of a word is being accepted this cycle
//   word       out  [31:0] assembled word (upper byte taken from byte_in)
// -----------------------------------------------------------------------------
module byte_packer
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [LANE_W-1:0] byte_in,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [LANE_CNT_W-1:0]         lane_q;
  logic [LANE_W*(LANES-1)-1:0]   low_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q <= '0;
      low_q  <= '0;
    end else if (clear) begin
      lane_q <= '0;
      low_q  <= '0;
    end else if (byte_en) begin
      if (lane_q == LANE_LAST) begin
        lane_q <= '0;
      end else begin
        lane_q <= lane_q + 1'b1;
        low_q[lane_q*LANE_W +: LANE_W] <= byte_in;
      end
    end
  end

  // The top byte is never stored: the word is forwarded as it completes so
  // the parent can register data and address on the same edge.
  assign word_valid = byte_en && (lane_q == LANE_LAST);
  assign word       = {byte_in, low_q};

endmodule

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
// Streams a program into instruction memory while holding the CPU in reset.
// After an accepted start, num_words words are received as a byte stream,
// written one at a time (initialize + data + address), then cpu_rst is held
// for RST_HOLD more cycles before the load is reported done.
//
// Optional feature (macro INSTR_LOADER_CHECKSUM_EN): an 8-bit modulo-256 sum
// of the program bytes is compared against one extra trailing byte; a
// mismatch sets error instead of done, but the CPU is still reset.
//
// Byte handshake: a byte transfers on a rising edge where byte_valid and
// byte_ready are both 1. byte_ready is a function of state only, so it never
// depends on byte_valid; byte_valid may be raised or dropped on any cycle.
//
// Parameters:
//   ADDR_BASE  byte address of word 0
//   MAX_WORDS  largest legal program length in words
//   RST_HOLD   cycles cpu_rst stays high after the last write (>= 1)
//
// Ports:
//   clk, rst                        clock / async active-low reset
//   start, num_words[15:0]          load request and length
//   byte_in[7:0], byte_valid        program byte stream
//   byte_ready                      block accepts a byte this cycle
//   initialize                      memory write enable / fetch override
//   instruction_initialize_data     [31:0] word to write
//   instruction_initialize_address  [31:0] byte address to write
//   cpu_rst                         active-high CPU reset
//   busy                            load in progress
//   done, error                     sticky status of the last request
//   state_dbg                       current FSM state
// -----------------------------------------------------------------------------
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          MAX_WORDS = 64,
  parameter int          RST_HOLD  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] num_words,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        initialize,
  output logic [31:0] instruction_initialize_data,
  output logic [31:0] instruction_initialize_address,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        error,
  output state_t      state_dbg
);

  localparam logic [15:0] MAX_W     = 16'(MAX_WORDS);
  localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);

  state_t      state_q, state_d;
  logic [15:0] num_q;
  logic [15:0] word_cnt_q;
  logic [15:0] hold_cnt_q;
  logic        words_done_q;

  logic        len_ok;
  logic        accept;
  logic        reject;
  logic        byte_fire;
  logic        load_byte;
  logic        word_valid;
  logic [31:0] word;
  logic        last_word;
  logic        in_write_d;
  logic        in_write_q;

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]  sum_q;
`endif

  assign len_ok    = (num_words != 16'd0) && (num_words <= MAX_W);
  assign accept    = (state_q == ST_IDLE) && start && len_ok;
  assign reject    = (state_q == ST_IDLE) && start && !len_ok;
  assign byte_fire = byte_valid && byte_ready;
  assign load_byte = byte_fire && (state_q == ST_LOAD);
  assign last_word = word_valid && (word_cnt_q == num_q - 16'd1);
  assign state_dbg = state_q;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept),
    .byte_en    (load_byte),
    .byte_in    (byte_in),
    .word_valid (word_valid),
    .word       (word)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // LOAD lingers one cycle after the last word is registered so that word is
  // presented with initialize still high before the write window closes.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_LOAD;
      end
      ST_LOAD: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (words_done_q) state_d = ST_CHECK;
`else
        if (words_done_q) state_d = ST_HOLD;
`endif
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (byte_fire) state_d = ST_HOLD;
      end
`endif
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    cpu_rst    = 1'b0;
    in_write_q = 1'b0;
    in_write_d = 1'b0;
    case (state_q)
      ST_LOAD: begin
        byte_ready = !words_done_q;
        busy       = 1'b1;
        cpu_rst    = 1'b1;
        in_write_q = 1'b1;
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        cpu_rst    = 1'b1;
        in_write_q = 1'b1;
      end
`endif
      ST_HOLD: begin
        busy    = 1'b1;
        cpu_rst = 1'b1;
      end
      default: ;
    endcase
`ifdef INSTR_LOADER_CHECKSUM_EN
    in_write_d = (state_d == ST_LOAD) || (state_d == ST_CHECK);
`else
    in_write_d = (state_d == ST_LOAD);
`endif
  end

  // ---------------------------------------------------------------------------
  // Datapath: write port, counters, sticky status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_q                          <= '0;
      word_cnt_q                     <= '0;
      words_done_q                   <= 1'b0;
      hold_cnt_q                     <= '0;
      initialize                     <= 1'b0;
      instruction_initialize_data    <= '0;
      instruction_initialize_address <= '0;
      done                           <= 1'b0;
      error                          <= 1'b0;
    end else begin
      if (accept) begin
        num_q        <= num_words;
        word_cnt_q   <= '0;
        words_done_q <= 1'b0;
        done         <= 1'b0;
        error        <= 1'b0;
      end

      if (reject) begin
        error <= 1'b1;
        done  <= 1'b0;
      end

      // Data and address only move together at word boundaries, so while
      // initialize is high the memory sees each pair once per word.
      if (word_valid) begin
        instruction_initialize_data    <= word;
        instruction_initialize_address <= word_addr(ADDR_BASE, word_cnt_q);
        word_cnt_q                     <= word_cnt_q + 16'd1;
        initialize                     <= 1'b1;
        if (last_word) words_done_q <= 1'b1;
      end

      if (in_write_q && !in_write_d) initialize <= 1'b0;

      if (state_q == ST_HOLD) hold_cnt_q <= hold_cnt_q + 16'd1;
      else                    hold_cnt_q <= '0;

      // error can only be set during this load by a checksum mismatch.
      if ((state_q == ST_HOLD) && (state_d == ST_FINISH) && !error)
        done <= 1'b1;

`ifdef INSTR_LOADER_CHECKSUM_EN
      if ((state_q == ST_CHECK) && byte_fire && (byte_in != sum_q))
        error <= 1'b1;
`endif
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           sum_q <= '0;
    else if (accept)    sum_q <= '0;
    else if (load_byte) sum_q <= sum_q + byte_in;
  end
`endif

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
// Two loaders (default ADDR_BASE and ADDR_BASE=FFFF_FFFC) receive identical
// stimulus. Expected memory writes come from a byte-level model of the
// program and are queued per instance; one monitor per instance pops and
// compares every write it observes (initialize rising, or data/address
// changing while initialize is high). Load-level status is checked by the
// driver. Build with +define+INSTR_LOADER_CHECKSUM_EN to also send and check
// the trailing checksum byte.
// -----------------------------------------------------------------------------
module tb_instr_loader;
  import instr_loader_pkg::*;

  localparam logic [31:0] BASE0    = 32'h0000_0000;
  localparam logic [31:0] BASE1    = 32'hFFFF_FFFC;
  localparam int          RST_HOLD = 4;
  localparam int          MAXW     = 64;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start;
  logic [15:0] num_words;
  logic [7:0]  byte_in;
  logic        byte_valid;

  logic        rdy     [2];
  logic        init_o  [2];
  logic [31:0] data_o  [2];
  logic [31:0] addr_o  [2];
  logic        cpu_o   [2];
  logic        busy_o  [2];
  logic        done_o  [2];
  logic        err_o   [2];
  state_t      st      [2];

  instr_loader #(.ADDR_BASE(BASE0), .MAX_WORDS(MAXW), .RST_HOLD(RST_HOLD)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(rdy[0]),
    .initialize(init_o[0]), .instruction_initialize_data(data_o[0]),
    .instruction_initialize_address(addr_o[0]), .cpu_rst(cpu_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .error(err_o[0]), .state_dbg(st[0])
  );

  instr_loader #(.ADDR_BASE(BASE1), .MAX_WORDS(MAXW), .RST_HOLD(RST_HOLD)) dut_hi (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(rdy[1]),
    .initialize(init_o[1]), .instruction_initialize_data(data_o[1]),
    .instruction_initialize_address(addr_o[1]), .cpu_rst(cpu_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .error(err_o[1]), .state_dbg(st[1])
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  logic [7:0]  prog_q[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: word i of the program and its wrapped byte address.
  function automatic logic [31:0] ref_word(input int i);
    return 32'(prog_q[4*i]) + 32'(prog_q[4*i+1]) * 32'd256 +
           32'(prog_q[4*i+2]) * 32'd65536 + 32'(prog_q[4*i+3]) * 32'd16777216;
  endfunction

  function automatic logic [31:0] ref_addr(input logic [31:0] base, input int i);
    logic [63:0] full;
    full = 64'(base) + 64'(4 * i);
    return full[31:0];
  endfunction

  task automatic push_exp(input int i);
    exp_q0.push_back({ref_addr(BASE0, i), ref_word(i)});
    exp_q1.push_back({ref_addr(BASE1, i), ref_word(i)});
  endtask

  // ---------------------------------------------------------------------------
  // Monitors: one write event per new (address, data) pair under initialize
  // ---------------------------------------------------------------------------
  logic        prev_init [2] = '{1'b0, 1'b0};
  logic [63:0] prev_pair [2] = '{64'd0, 64'd0};

  always @(negedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (rst && init_o[w] && (!prev_init[w] || {addr_o[w], data_o[w]} != prev_pair[w])) begin
        if ((w == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
          chk_cnt++;
          $display("FAIL write%0d_unexpected: got addr=%h data=%h expected no write",
                   w, addr_o[w], data_o[w]);
        end else if (w == 0) begin
          check("write0", {addr_o[0], data_o[0]}, exp_q0.pop_front());
        end else begin
          check("write1", {addr_o[1], data_o[1]}, exp_q1.pop_front());
        end
      end
      prev_init[w] = rst && init_o[w];
      prev_pair[w] = {addr_o[w], data_o[w]};
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all return on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic do_start(input int n);
    start     = 1'b1;
    num_words = 16'(n);
    @(negedge clk);
    start     = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 random idle gaps, 2 valid every other cycle.
  // Idle gaps also fire stray start pulses, which a busy loader must ignore.
  task automatic send_byte(input logic [7:0] b, input int gap_mode);
    int gaps;
    int n;
    case (gap_mode)
      0:       gaps = 0;
      1:       gaps = $urandom_range(0, 2);
      default: gaps = 1;
    endcase
    for (int g = 0; g < gaps; g++) begin
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
      start      = ($urandom_range(0, 3) == 0);
      num_words  = 16'($urandom_range(1, 64));
      @(negedge clk);
    end
    start      = 1'b0;
    byte_valid = 1'b1;
    byte_in    = b;
    n = 0;
    while (!rdy[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[0]) begin
      chk_cnt++;
      $display("FAIL byte_ready_timeout: got ready=0 expected 1");
    end else begin
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic fill_random(input int n);
    prog_q.delete();
    for (int i = 0; i < 4 * n; i++) prog_q.push_back(8'($urandom));
  endtask

  task automatic run_load(input int n, input int gap_mode, input bit bad_sum);
    int   sum;
    int   hold;
    int   k;
    sum = 0;
    for (int i = 0; i < n; i++) push_exp(i);
    do_start(n);
    for (int j = 0; j < 4 * n; j++) begin
      send_byte(prog_q[j], gap_mode);
      sum += int'(prog_q[j]);
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(bad_sum ? 8'(sum + 1) : 8'(sum), gap_mode);
`endif
    hold = 0;
    k    = 0;
    while (busy_o[0] && k < 300) begin
      if (cpu_o[0] && !init_o[0]) hold++;
      @(negedge clk);
      k++;
    end
    check("load_ends", busy_o[0], 0);
    check("hold_cycles", hold, RST_HOLD);
    check("finish_cpu_rst", {cpu_o[0], cpu_o[1]}, 0);
    check("finish_done", {done_o[0], done_o[1]}, bad_sum ? 2'b00 : 2'b11);
    check("finish_error", {err_o[0], err_o[1]}, bad_sum ? 2'b11 : 2'b00);
    check("writes_left", exp_q0.size() + exp_q1.size(), 0);
    @(negedge clk);
    check("back_idle", 64'(st[0]), 64'(ST_IDLE));
  endtask

  task automatic reject_test(input int n);
    do_start(n);
    check("reject_error", {err_o[0], err_o[1]}, 2'b11);
    check("reject_done", {done_o[0], done_o[1]}, 2'b00);
    check("reject_busy", {busy_o[0], busy_o[1]}, 2'b00);
    check("reject_state", 64'(st[0]), 64'(ST_IDLE));
    for (int c = 0; c < 3; c++) begin
      check("reject_quiet", {init_o[0], cpu_o[0], init_o[1], cpu_o[1]}, 4'b0000);
      @(negedge clk);
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int w = 0; w < 2; w++) begin
      check(name, {rdy[w], init_o[w], cpu_o[w], busy_o[w], done_o[w], err_o[w]}, 6'b0);
      check(name, {addr_o[w], data_o[w]}, 64'd0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  logic [7:0] req26 [8] = '{8'h13, 8'h00, 8'h01, 8'h20, 8'h00, 8'h00, 8'h00, 8'h08};

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    num_words  = '0;
    byte_in    = '0;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    check("reset_state", 64'(st[0]), 64'(ST_IDLE));
    rst = 1'b1;
    @(negedge clk);

    // Two-word directed program; second instance wraps FFFF_FFFC -> 0.
    prog_q.delete();
    for (int i = 0; i < 8; i++) prog_q.push_back(req26[i]);
    run_load(2, 0, 1'b0);

    // Illegal lengths.
    reject_test(0);
    reject_test(MAXW + 1);

    // Single word, valid toggling every other cycle.
    fill_random(1);
    run_load(1, 2, 1'b0);

    // Random programs with random gaps and stray start pulses.
    for (int t = 0; t < 8; t++) begin
      int n;
      n = $urandom_range(1, 6);
      fill_random(n);
      run_load(n, $urandom_range(0, 1), 1'b0);
    end

    // Longest legal program.
    fill_random(MAXW);
    run_load(MAXW, 0, 1'b0);

    // Reset after the 6th byte of a 3-word load: only word 0 was written.
    fill_random(3);
    push_exp(0);
    do_start(3);
    for (int j = 0; j < 6; j++) send_byte(prog_q[j], 1);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midload_reset");
    check("midload_state", 64'(st[0]), 64'(ST_IDLE));
    check("midload_writes_left", exp_q0.size() + exp_q1.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    fill_random(1);
    run_load(1, 0, 1'b0);

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Bytes 01..04 sum to 0A: correct and wrong trailing byte.
    prog_q.delete();
    for (int i = 1; i <= 4; i++) prog_q.push_back(8'(i));
    run_load(1, 0, 1'b0);
    run_load(1, 1, 1'b1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
